// File: rtl/mac_accelerator_if.sv
// Register bus between the TinyQV core and a peripheral: 4-bit address,
// 8-bit write data with strobe, combinational 8-bit read data.
interface mac_accelerator_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output address, output data_write, output data_in, input data_out);
  modport slave  (input address, input data_write, input data_in, output data_out);
endinterface

// File: rtl/mac_accelerator.sv
// Memory-mapped multiply-accumulate peripheral: sequential 8x8 shift-add
// multiply feeding an ACC_W-bit accumulator with a sticky overflow flag.
module mac_accelerator #(
  parameter int ACC_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        ui_in,
  output logic [7:0]        uo_out,
  mac_accelerator_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2
  } state_t;

  state_t             state_r;
  logic               busy_r;
  logic               done_r;
  logic               ovf_r;
  logic               accum_r;
  logic               signed_r;
  logic               auto_r;
  logic [7:0]         a_r;
  logic [7:0]         b_r;
  logic [ACC_W-1:0]   acc_r;
  logic [15:0]        mcand_r;
  logic [7:0]         mplier_r;
  logic [15:0]        prod_r;
  logic [2:0]         cnt_r;
  logic               neg_r;
  logic               w_accum_r;
  logic               w_signed_r;

  logic               wr_ctrl_s;
  logic               wr_a_s;
  logic               wr_b_s;
  logic               clr_s;
  logic               start_s;
  logic [7:0]         op_b_s;
  logic               op_accum_s;
  logic               op_signed_s;
  logic [ACC_W-1:0]   prod_ext_s;
  logic [ACC_W-1:0]   addend_s;
  logic [ACC_W:0]     sum_s;
  logic               ovf_add_s;
  logic [31:0]        acc32_s;
  logic               unused_ui_s;

  // Magnitude of an operand; -128 maps to 0x80, which is exact as unsigned.
  function automatic logic [7:0] mag8(input logic [7:0] v, input logic sgn);
    if (sgn && v[7]) begin
      return 8'd0 - v;
    end else begin
      return v;
    end
  endfunction

  assign unused_ui_s = ^ui_in;

  // Decode bus writes and decide whether an operation starts this cycle.
  always_comb begin
    wr_ctrl_s   = bus.data_write && (bus.address == 4'h0);
    wr_a_s      = bus.data_write && (bus.address == 4'h1);
    wr_b_s      = bus.data_write && (bus.address == 4'h2);
    clr_s       = wr_ctrl_s && bus.data_in[1];
    op_b_s      = wr_b_s ? bus.data_in : b_r;
    op_accum_s  = wr_ctrl_s ? bus.data_in[2] : accum_r;
    op_signed_s = wr_ctrl_s ? bus.data_in[3] : signed_r;
    // A same-write CLR frees the engine, so START is honoured even mid-run.
    if (wr_ctrl_s && bus.data_in[0] && ((state_r == ST_IDLE) || clr_s)) begin
      start_s = 1'b1;
    end else if (wr_b_s && auto_r && (state_r == ST_IDLE)) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
  end

  // Signed product, width-extended, and the accumulate sum with both overflow flavours.
  always_comb begin
    prod_ext_s        = {ACC_W{1'b0}};
    prod_ext_s[15:0]  = prod_r;
    if (neg_r) begin
      addend_s = {ACC_W{1'b0}} - prod_ext_s;
    end else begin
      addend_s = prod_ext_s;
    end
    sum_s = {1'b0, acc_r} + {1'b0, addend_s};
    if (w_signed_r) begin
      ovf_add_s = (acc_r[ACC_W-1] == addend_s[ACC_W-1]) && (sum_s[ACC_W-1] != acc_r[ACC_W-1]);
    end else begin
      ovf_add_s = sum_s[ACC_W];
    end
  end

  // Register file, multiply/accumulate FSM and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ovf_r      <= 1'b0;
      accum_r    <= 1'b0;
      signed_r   <= 1'b0;
      auto_r     <= 1'b0;
      a_r        <= 8'h00;
      b_r        <= 8'h00;
      acc_r      <= {ACC_W{1'b0}};
      mcand_r    <= 16'h0000;
      mplier_r   <= 8'h00;
      prod_r     <= 16'h0000;
      cnt_r      <= 3'd0;
      neg_r      <= 1'b0;
      w_accum_r  <= 1'b0;
      w_signed_r <= 1'b0;
    end else begin
      if (wr_ctrl_s) begin
        accum_r  <= bus.data_in[2];
        signed_r <= bus.data_in[3];
        auto_r   <= bus.data_in[4];
      end
      if (wr_a_s) begin
        a_r <= bus.data_in;
      end
      if (wr_b_s) begin
        b_r <= bus.data_in;
      end

      if (clr_s) begin
        acc_r   <= {ACC_W{1'b0}};
        ovf_r   <= 1'b0;
        done_r  <= 1'b0;
        busy_r  <= 1'b0;
        state_r <= ST_IDLE;
      end else begin
        case (state_r)
          ST_MUL: begin
            prod_r   <= prod_r + (mplier_r[0] ? mcand_r : 16'h0000);
            mcand_r  <= {mcand_r[14:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[7:1]};
            cnt_r    <= cnt_r + 3'd1;
            if (cnt_r == 3'd7) begin
              state_r <= ST_ACC;
            end
          end
          ST_ACC: begin
            if (w_accum_r) begin
              acc_r <= sum_s[ACC_W-1:0];
              if (ovf_add_s) begin
                ovf_r <= 1'b1;
              end
            end else begin
              acc_r <= addend_s;
            end
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
          default: begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end

      if (start_s) begin
        mcand_r    <= {8'h00, mag8(a_r, op_signed_s)};
        mplier_r   <= mag8(op_b_s, op_signed_s);
        prod_r     <= 16'h0000;
        cnt_r      <= 3'd0;
        neg_r      <= op_signed_s && (a_r[7] ^ op_b_s[7]);
        w_accum_r  <= op_accum_s;
        w_signed_r <= op_signed_s;
        done_r     <= 1'b0;
        busy_r     <= 1'b1;
        state_r    <= ST_MUL;
      end
    end
  end

  // Read mux; accumulator bits at or above ACC_W read as zero.
  always_comb begin
    acc32_s            = 32'h0000_0000;
    acc32_s[ACC_W-1:0] = acc_r;
    case (bus.address)
      4'h0:    bus.data_out = {3'b000, auto_r, ovf_r, done_r, busy_r};
      4'h1:    bus.data_out = a_r;
      4'h2:    bus.data_out = b_r;
      4'h3:    bus.data_out = {5'b00000, auto_r, signed_r, accum_r};
      4'h4:    bus.data_out = acc32_s[7:0];
      4'h5:    bus.data_out = acc32_s[15:8];
      4'h6:    bus.data_out = acc32_s[23:16];
      4'h7:    bus.data_out = acc32_s[31:24];
      default: bus.data_out = 8'h00;
    endcase
  end

  assign uo_out = {4'b0000, ovf_r, done_r, busy_r, 1'b0};

endmodule

// File: tb/tb_mac_accelerator.sv
// Bench for mac_accelerator: identical stimulus into a 24-bit and a 16-bit
// instance, table-driven operations plus hand-written timing corner cases.
module tb_mac_accelerator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo24;
  logic [7:0] uo16;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;

  always #10 clk = ~clk;

  mac_accelerator_if bus24();
  mac_accelerator_if bus16();

  assign bus24.address    = address;
  assign bus24.data_write = data_write;
  assign bus24.data_in    = data_in;
  assign bus16.address    = address;
  assign bus16.data_write = data_write;
  assign bus16.data_in    = data_in;

  mac_accelerator #(.ACC_W(24)) dut24 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo24), .bus(bus24)
  );
  mac_accelerator #(.ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo16), .bus(bus16)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  ctrl;
    logic [31:0] acc24;
    logic        ovf24;
    logic [31:0] acc16;
    logic        ovf16;
  } vec_t;

  typedef struct {
    logic [31:0] acc24;
    logic        ovf24;
    logic [31:0] acc16;
    logic        ovf16;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at (or just after) a negedge; the write is sampled at the next posedge.
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address    = a;
    data_in    = d;
    data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d24, output logic [7:0] d16);
    address = a;
    #1;
    d24 = bus24.data_out;
    d16 = bus16.data_out;
  endtask

  task automatic rd_acc(output logic [31:0] a24, output logic [31:0] a16);
    for (int i = 0; i < 4; i++) begin
      address = 4'(4 + i);
      #1;
      a24[8*i +: 8] = bus24.data_out;
      a16[8*i +: 8] = bus16.data_out;
    end
  endtask

  // Counts negedges with busy high; optionally injects one write at a given count.
  task automatic wait_idle(input int inject_at, input logic [3:0] ia, input logic [7:0] id,
                           output int cycles);
    cycles = 0;
    while (uo24[1] && cycles < 100) begin
      cycles++;
      if (cycles == inject_at) begin
        wr(ia, id);
      end else begin
        @(negedge clk);
      end
    end
    if (cycles >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy timeout: busy still high after %0d cycles, required low", cycles);
    end
  endtask

  task automatic check_result(input string tag, input logic auto_b, input logic done_b);
    exp_t        e;
    logic [31:0] a24, a16;
    logic [7:0]  s24, s16;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s scoreboard: queue empty, required an entry", tag);
      return;
    end
    e = sb_q.pop_front();
    rd_acc(a24, a16);
    check({tag, " acc24"}, a24, e.acc24);
    check({tag, " acc16"}, a16, e.acc16);
    rd(4'h0, s24, s16);
    check({tag, " status24"}, 32'(s24), 32'({3'b000, auto_b, e.ovf24, done_b, 1'b0}));
    check({tag, " status16"}, 32'(s16), 32'({3'b000, auto_b, e.ovf16, done_b, 1'b0}));
    check({tag, " uo24"}, 32'(uo24), 32'({4'b0000, e.ovf24, done_b, 2'b00}));
    check({tag, " uo16"}, 32'(uo16), 32'({4'b0000, e.ovf16, done_b, 2'b00}));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic [7:0]  d24, d16;
    exp_t        e;

    vecs[0]  = '{8'd12,  8'd10,  8'h01, 32'h000078, 1'b0, 32'h0078, 1'b0};
    vecs[1]  = '{8'hFF,  8'hFF,  8'h05, 32'h00FE79, 1'b0, 32'hFE79, 1'b0};
    vecs[2]  = '{8'hFF,  8'hFF,  8'h05, 32'h01FC7A, 1'b0, 32'hFC7A, 1'b1};
    vecs[3]  = '{8'hFE,  8'h03,  8'h09, 32'hFFFFFA, 1'b0, 32'hFFFA, 1'b1};
    vecs[4]  = '{8'h00,  8'h00,  8'h02, 32'h000000, 1'b0, 32'h0000, 1'b0};
    vecs[5]  = '{8'h80,  8'h80,  8'h0D, 32'h004000, 1'b0, 32'h4000, 1'b0};
    vecs[6]  = '{8'h80,  8'h80,  8'h0D, 32'h008000, 1'b0, 32'h8000, 1'b1};
    vecs[7]  = '{8'h7F,  8'h81,  8'h0D, 32'h0040FF, 1'b0, 32'h40FF, 1'b1};
    vecs[8]  = '{8'h00,  8'h00,  8'h02, 32'h000000, 1'b0, 32'h0000, 1'b0};
    vecs[9]  = '{8'h81,  8'h02,  8'h0D, 32'hFFFF02, 1'b0, 32'hFF02, 1'b0};
    vecs[10] = '{8'h10,  8'h10,  8'h01, 32'h000100, 1'b0, 32'h0100, 1'b0};
    vecs[11] = '{8'hFF,  8'hFF,  8'h07, 32'h00FE01, 1'b0, 32'hFE01, 1'b0};

    rst_n      = 1'b0;
    ui_in      = 8'h00;
    address    = 4'h0;
    data_in    = 8'h00;
    data_write = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state: every address reads zero.
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), d24, d16);
      check($sformatf("reset rd24[%0d]", i), 32'(d24), 32'h0);
      check($sformatf("reset rd16[%0d]", i), 32'(d16), 32'h0);
    end
    check("reset uo24", 32'(uo24), 32'h0);
    check("reset uo16", 32'(uo16), 32'h0);
    @(negedge clk);

    // Table-driven operations through the scoreboard.
    for (int i = 0; i < 12; i++) begin
      wr(4'h1, vecs[i].a);
      wr(4'h2, vecs[i].b);
      e = '{vecs[i].acc24, vecs[i].ovf24, vecs[i].acc16, vecs[i].ovf16};
      sb_q.push_back(e);
      wr(4'h0, vecs[i].ctrl);
      if (vecs[i].ctrl[0]) begin
        wait_idle(0, 4'h0, 8'h00, cyc);
        check($sformatf("vec%0d busy cycles", i), 32'(cyc), 32'd9);
      end
      check_result($sformatf("vec%0d", i), 1'b0, vecs[i].ctrl[0]);
    end

    // Signed AUTO start from a B write, with an ignored START mid-run.
    wr(4'h0, 8'h02);
    wr(4'h0, 8'h18);
    wr(4'h1, 8'hFE);
    sb_q.push_back('{32'hFFFFFA, 1'b0, 32'hFFFA, 1'b0});
    wr(4'h2, 8'h03);
    wait_idle(3, 4'h0, 8'h19, cyc);
    check("auto busy cycles", 32'(cyc), 32'd9);
    rd(4'h3, d24, d16);
    check("auto mode24", 32'(d24), 32'h06);
    check("auto mode16", 32'(d16), 32'h06);
    check_result("auto", 1'b1, 1'b1);

    // Back-to-back: START in the cycle after done rises; unsigned carry sets ovf.
    sb_q.push_back('{32'h0002F4, 1'b1, 32'h02F4, 1'b1});
    wr(4'h0, 8'h05);
    wait_idle(0, 4'h0, 8'h00, cyc);
    check("b2b busy cycles", 32'(cyc), 32'd9);
    check_result("b2b", 1'b0, 1'b1);

    // Abort with CLR four cycles after START.
    sb_q.push_back('{32'h0, 1'b0, 32'h0, 1'b0});
    wr(4'h0, 8'h01);
    wait_idle(4, 4'h0, 8'h02, cyc);
    check("abort busy cycles", 32'(cyc), 32'd4);
    check_result("abort", 1'b0, 1'b0);

    // Restart after abort; an A write mid-run only affects the next operation.
    sb_q.push_back('{32'h0002FA, 1'b0, 32'h02FA, 1'b0});
    wr(4'h0, 8'h01);
    wait_idle(2, 4'h1, 8'h05, cyc);
    check("restart busy cycles", 32'(cyc), 32'd9);
    check_result("restart", 1'b0, 1'b1);
    sb_q.push_back('{32'h00000F, 1'b0, 32'h000F, 1'b0});
    wr(4'h0, 8'h01);
    wait_idle(0, 4'h0, 8'h00, cyc);
    check("newA busy cycles", 32'(cyc), 32'd9);
    check_result("newA", 1'b0, 1'b1);

    // Reset asserted mid-operation.
    wr(4'h0, 8'h05);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd(4'(i), d24, d16);
      check($sformatf("midrst rd24[%0d]", i), 32'(d24), 32'h0);
      check($sformatf("midrst rd16[%0d]", i), 32'(d16), 32'h0);
    end
    check("midrst uo24", 32'(uo24), 32'h0);
    check("midrst uo16", 32'(uo16), 32'h0);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_accelerator.md
# mac_accelerator

Memory-mapped multiply-accumulate peripheral for the TinyQV peripheral bus. It is the parametrised successor to the single-register example peripheral and keeps the same 4-bit address, 8-bit data bus. The software writes two 8-bit operands and a control word. The block then runs a sequential shift-add multiply and adds the product into (or loads it into) an ACC_W-bit accumulator, which software reads back byte by byte. Status is also mirrored on the output PMOD.

## Interface
- ACC_W, 24, accumulator width in bits; legal range 16..32.
- clk  input  1  project clock (nominally 64 MHz).
- rst_n  input  1  reset; synchronous, active-low.
- ui_in  input  8  input PMOD; unused.
- uo_out  output  8  {4'b0, ovf, done, busy, 1'b0}; bit0 is held 0 (UART TX slot).
- address  input  4  register select.
- data_write  input  1  write strobe; data_in is valid when it is high.
- data_in  input  8  write data.
- data_out  output  8  read data for `address`; combinational.

## Operation
- Register map:
  - 0x0 CTRL (write): bit0 START, bit1 CLR, bit2 ACCUM (1: acc += A*B, 0: acc = A*B), bit3 SIGNED (two's-complement operands), bit4 AUTO.
  - 0x0 STATUS (read): {3'b0, auto, ovf, done, busy}.
  - 0x1 A (RW).
  - 0x2 B (RW).
  - 0x3 MODE (read): {5'b0, auto, signed, accum}.
  - 0x4..0x7 ACC bytes 0..3 (read-only). Bits at or above ACC_W read 0. Writes to these addresses are ignored.
  - 0x8..0xF read 0.
- The ACCUM, SIGNED and AUTO bits are latched on every CTRL write.
- AUTO=1: a write to B while idle also issues START, using the new B value.
- START while busy is ignored. A and B writes while busy are accepted and apply only to the next operation.
- On START, A, B and the mode bits are captured into working registers. Done is cleared.
- FSM:
  - IDLE -> MUL on START.
  - MUL runs 8 cycles, one multiplier bit per cycle. It is an unsigned 8x8 multiply on magnitudes; in SIGNED mode the operands are negated first when negative.
  - MUL -> ACC. ACC applies the sign, sign-extends (SIGNED) or zero-extends the 16-bit product to ACC_W, then adds it to or loads it into acc.
  - ACC -> IDLE with done=1.
- Arithmetic: acc wraps modulo 2^ACC_W.
- ovf is sticky. It is set when an ACCUM add overflows: unsigned carry-out when SIGNED=0, two's-complement overflow when SIGNED=1. A load never sets ovf.
- CLR: acc=0, ovf=0, done=0. If busy, the operation is aborted and the FSM returns to IDLE.
- CLR and START in the same write: the clear applies first, then the operation starts with acc=0.
- Reset values: acc=0, A=0, B=0, all mode bits 0, busy=0, done=0, ovf=0, FSM=IDLE. Therefore data_out=0 and uo_out=0.

## Timing
- Writes are sampled at the posedge where data_write=1.
- START accepted at edge N:
  - busy=1 after edge N.
  - MUL occupies edges N+1..N+8.
  - ACC at edge N+9 updates acc and ovf, sets done=1 and busy=0.
  - busy is therefore visible for exactly 9 cycles.
- Back-to-back: a START written in the cycle after done rises is accepted.
- A CLR at any edge during MUL or ACC takes effect at that edge: no acc update, done=0.
- A reset asserted mid-operation has the same effect as power-on reset at the next edge.
- data_out reflects register state in the same cycle; there is no read latency.

## Test plan
- Reset: hold rst_n=0 for 2 cycles -> every readable address returns 0x00 and uo_out=0x00.
- Unsigned load: A=12, B=10, CTRL=0x01 -> busy high for exactly 9 cycles, then STATUS=0x02 and ACC bytes read 0x78,0x00,0x00.
- Accumulate: from 0x78, A=255, B=255, CTRL=0x05 -> acc=0x00FE79, ovf=0.
- Signed and AUTO: CTRL=0x18, A=0xFE, write B=3 -> auto-start; for ACC_W=24 acc=0xFFFFFA. A START issued mid-run is ignored, so the cycle count is unchanged.
- Overflow with ACC_W=16: two unsigned accumulates of 255*255 -> acc=0xFC02, ovf=1. ovf stays set through a later load, and CTRL=0x02 clears it.
- Abort: CLR written 4 cycles after START -> busy=0 on the next cycle, acc=0, done stays 0. A subsequent START completes normally.
